// File: rtl/week_5_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and vector-count helper.
package week_5_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int unsigned vec_count(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/week_5_sweep_order.sv
// Maps a sweep index to the stimulus value driven onto the exercise circuit.
// Optional macro SWEEPER_GRAY_ORDER_EN selects reflected Gray order instead of binary ascending.
module week_5_sweep_order #(
  parameter int N_IN = 7
) (
  input  logic [N_IN-1:0] idx,
  output logic [N_IN-1:0] stim
);

`ifdef SWEEPER_GRAY_ORDER_EN
  // Neighbouring vectors differ in exactly one input bit.
  assign stim = idx ^ (idx >> 1);
`else
  assign stim = idx;
`endif

endmodule

// File: rtl/week_5_truth_table_sweeper.sv
// Exhaustive truth-table self-test: drives every input vector, waits SETTLE cycles, compares dut_y.
// Optional macro SWEEPER_GRAY_ORDER_EN (in week_5_sweep_order) switches the sweep to Gray order.
module week_5_truth_table_sweeper
  import week_5_sweeper_pkg::*;
#(
  parameter int N_IN   = 7,
  parameter int SETTLE = 2,
  parameter int CNT_W  = N_IN + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [(2**N_IN)-1:0]       expected,
  input  logic                       dut_y,
  output logic [N_IN-1:0]            stim,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [CNT_W-1:0]           mismatch_cnt,
  output logic                       first_fail_vld,
  output logic [N_IN-1:0]            first_fail_vec
);

  localparam int unsigned NV = vec_count(N_IN);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = N_IN'(NV - 1);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
  logic              first_fail_vld_q, first_fail_vld_d;
  logic [N_IN-1:0]   first_fail_vec_q, first_fail_vec_d;

  logic [N_IN-1:0]   order_idx;
  logic [N_IN-1:0]   order_stim;
  logic              mismatch;

  // The only index ever needed next is idx+1 (from SAMPLE) or 0 (fresh start).
  assign order_idx = (state_q == ST_SAMPLE) ? (idx_q + N_IN'(1)) : '0;

  week_5_sweep_order #(.N_IN(N_IN)) u_order (
    .idx  (order_idx),
    .stim (order_stim)
  );

  assign mismatch = (dut_y != expected[stim_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      settle_cnt_q     <= '0;
      stim_q           <= '0;
      mismatch_cnt_q   <= '0;
      first_fail_vld_q <= 1'b0;
      first_fail_vec_q <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      settle_cnt_q     <= settle_cnt_d;
      stim_q           <= stim_d;
      mismatch_cnt_q   <= mismatch_cnt_d;
      first_fail_vld_q <= first_fail_vld_d;
      first_fail_vec_q <= first_fail_vec_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    settle_cnt_d     = settle_cnt_q;
    stim_d           = stim_q;
    mismatch_cnt_d   = mismatch_cnt_q;
    first_fail_vld_d = first_fail_vld_q;
    first_fail_vec_d = first_fail_vec_q;

    if (abort) begin
      // Results and stimulus freeze where they are; only the sweep stops.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d          = ST_DRIVE;
            idx_d            = '0;
            stim_d           = order_stim;
            settle_cnt_d     = '0;
            mismatch_cnt_d   = '0;
            first_fail_vld_d = 1'b0;
            first_fail_vec_d = '0;
          end
        end
        ST_DRIVE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d = ST_SAMPLE;
          end else begin
            settle_cnt_d = settle_cnt_q + SW'(1);
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            if (mismatch_cnt_q != '1) begin
              mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
            end
            if (!first_fail_vld_q) begin
              first_fail_vld_d = 1'b1;
              first_fail_vec_d = stim_q;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_DRIVE;
            idx_d        = idx_q + N_IN'(1);
            stim_d       = order_stim;
            settle_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign stim           = stim_q;
  assign busy           = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (mismatch_cnt_q == '0);
  assign mismatch_cnt   = mismatch_cnt_q;
  assign first_fail_vld = first_fail_vld_q;
  assign first_fail_vec = first_fail_vec_q;

endmodule

// File: doc/week_5_truth_table_sweeper.md
Name: week_5_truth_table_sweeper

Overview:
Sequential self-test engine for the course's N-input, 1-output combinational exercise circuits.
- Drives every input combination onto a DUT and holds each for a programmable settle time.
- Samples the DUT output and compares it against an expected truth table, counting mismatches and recording the first failing vector.
- Sits beside a combinational exercise module at the top level, replacing hand-written stimulus lists.

Parameters:
N_IN, 7, number of DUT inputs (1..10); the sweep covers 2**N_IN vectors
SETTLE, 2, cycles each vector is held before sampling (>=1)
CNT_W, N_IN+1, width of the mismatch counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a sweep; sampled in IDLE or DONE
abort  in  1  return to IDLE immediately; has priority over start
expected  in  2**N_IN  expected Y; bit i = expected output for stimulus value i
dut_y  in  1  DUT output
stim  out  N_IN  registered stimulus to the DUT inputs
busy  out  1  high in DRIVE or SAMPLE
done  out  1  high in DONE
pass  out  1  valid when done; 1 iff mismatch_cnt==0
mismatch_cnt  out  CNT_W  number of failing vectors, saturating
first_fail_vld  out  1  a mismatch has been recorded this sweep
first_fail_vec  out  N_IN  stimulus value of the first mismatch

Behaviour:
- Reset (async, rst_n=0): state=IDLE, stim=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_vld=0, first_fail_vec=0. All internal counters are cleared.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE -> DRIVE on start=1:
  - idx=0, stim=order(0), settle_cnt=0.
  - mismatch_cnt, first_fail_vld and first_fail_vec are cleared in the same edge.
- DRIVE: settle_cnt increments each cycle. When settle_cnt==SETTLE-1, go to SAMPLE. stim is held constant.
- SAMPLE, one cycle: compare dut_y against expected[stim].
  - On mismatch: mismatch_cnt increments, saturating at all-ones.
  - On the first mismatch of a sweep: first_fail_vld=1, first_fail_vec=stim.
  - If idx==2**N_IN-1, go to DONE. Otherwise idx++, stim=order(idx+1), settle_cnt=0, go to DRIVE.
- DONE: done=1, pass=(mismatch_cnt==0); results are held.
  - start=1 restarts exactly as from IDLE.
  - Otherwise the block remains in DONE.
- order(i) = i (binary ascending) unless the optional feature is enabled.
- Latency: with start accepted at edge k, stim for vector i is stable from edge k+i*(SETTLE+1). done rises at edge k+2**N_IN*(SETTLE+1).
- abort=1 in any state: next state IDLE, busy=0, done=0, pass=0. Counters and the first-fail record keep their values.
- start while busy is ignored. Simultaneous start and abort: abort wins.
- pass is 0 whenever done=0.
- expected and dut_y are sampled only in SAMPLE. Changing expected mid-sweep affects only the vectors not yet sampled.
- A mid-sweep rst_n assertion clears everything asynchronously. There is no partial-result retention.

Optional Feature:
- Macro: SWEEPER_GRAY_ORDER_EN.
- Defined: order(i) = i ^ (i>>1), so consecutive stimuli differ in exactly one bit. Comparison still indexes expected by the stim value. first_fail_vec reports the stim value, not idx.
- Undefined: binary ascending order; no Gray logic is synthesised.

Decomposition:
- Shared package week_5_sweeper_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_SAMPLE=2'd2, ST_DONE=2'd3
  - a function for vector count (1<<N_IN)
- One sub-module, week_5_sweep_order: combinational idx -> stim mapping, containing the Gray option.
- Counters and the FSM stay in the top module.

Test Plan:
- N_IN=3, SETTLE=2, expected=8'b1000_0000 (3-input AND), DUT = correct AND, start pulse -> stim steps 0..7, each held 3 cycles; done at start+24; pass=1, mismatch_cnt=0, first_fail_vld=0.
- Same setup, DUT output forced to 1 for stim=5 -> mismatch_cnt=1, first_fail_vec=3'd5, pass=0.
- DUT tied to constant 1 with expected=8'h80 -> mismatch_cnt=7, first_fail_vec=0, pass=0; restart via start from DONE clears the counts.
- abort asserted on the 4th vector's SAMPLE cycle, together with start -> IDLE next cycle, done=0, busy=0; a later start sweeps from stim=0.
- rst_n pulsed low mid-DRIVE, asynchronously between edges -> all outputs zero immediately, state IDLE.
- SWEEPER_GRAY_ORDER_EN defined, N_IN=3 -> stim sequence 0,1,3,2,6,7,5,4; each step changes exactly one bit; a correct DUT gives pass=1.
